cosim_uart_rx: RTL and testbench



---
 rtl/cosim_uart_rx_pkg.sv | 15 +
 rtl/cosim_sync2.sv | 27 ++
 rtl/cosim_uart_rx.sv | 146 ++++++++++++++
 tb/tb_cosim_uart_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_uart_rx_pkg.sv
// Shared definitions for the cosim UART link, used by both the receiver and the
// matching transmitter.
package cosim_uart_rx_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/cosim_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; both flops reset to RST_VAL
// so an idle-high line does not look like a start bit coming out of reset.
module cosim_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= d_i;
            r_q    <= r_meta;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/cosim_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a divided bit timer, single holding
// register with valid/ready, one-cycle framing-error and overrun pulses.
module cosim_uart_rx
    import cosim_uart_rx_pkg::*;
#(
    parameter int BAUD_RATE = 10_000_000,
    parameter int CLK_FREQ  = 50_000_000
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_divider
        $error("cosim_uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    logic                      w_rx_s;
    logic                      w_stop_tick;
    logic                      w_byte_done;
    logic                      w_accept;

    rx_state_t                 r_state;
    logic [CNT_W-1:0]          r_clk_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_overrun;

    cosim_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .d_i     (rx_i),
        .q_o     (w_rx_s)
    );

    assign w_stop_tick = (r_state == STOP) && (r_clk_cnt == CNT_LAST);
    assign w_byte_done = w_stop_tick && w_rx_s;
    // A byte may land in the holding register in the same cycle the old one leaves it.
    assign w_accept    = !r_valid || ready_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state   <= START;
                        r_clk_cnt <= '0;
                    end
                end
                START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_byte_done) begin
                if (w_accept) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_cosim_uart_rx.sv
// Bench for cosim_uart_rx: directed scenarios plus random frames, checked every
// cycle against a transaction-level model of frame completion and the holding register.
module tb_cosim_uart_rx;

    localparam int CPB = 5;

    typedef struct {
        int         edge_no;
        logic       good;
        logic [7:0] data;
    } ev_t;

    logic       clk_i;
    logic       arstn_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;

    int n_checks;
    int n_errors;
    int edge_n;
    int dut_ferr_cnt;
    int dut_ovr_cnt;
    logic rand_ready;

    ev_t evq[$];
    int         ld_edge[$];
    logic [7:0] ld_data[$];

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ferr;
    logic       m_ovr;
    logic       prev_v;

    cosim_uart_rx #(
        .BAUD_RATE (10_000_000),
        .CLK_FREQ  (50_000_000)
    ) dut (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
    endtask

    // Frame starts on the next edge; the stop-bit decision lands 49 edges later.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int start_edge);
        logic [9:0] bits;
        ev_t ev;
        bits = {stop, b, 1'b0};
        start_edge = edge_n + 1;
        ev.edge_no = start_edge + 49;
        ev.good    = stop;
        ev.data    = b;
        evq.push_back(ev);
        for (int i = 0; i < 10; i++) begin
            rx_i = bits[i];
            repeat (CPB) tick();
        end
    endtask

    // Model and per-cycle compare
    initial begin
        m_data = '0; m_valid = 0; m_ferr = 0; m_ovr = 0; prev_v = 0;
        forever begin
            logic rdy, done, bad;
            logic [7:0] nb;
            @(posedge clk_i);
            edge_n++;
            rdy = ready_i; done = 0; bad = 0; nb = '0;
            if (!arstn_i) begin
                evq.delete();
                m_data = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
            end else begin
                if (evq.size() > 0 && evq[0].edge_no == edge_n) begin
                    if (evq[0].good) begin done = 1; nb = evq[0].data; end
                    else bad = 1;
                    void'(evq.pop_front());
                end
                m_ferr = bad;
                m_ovr  = 0;
                if (done) begin
                    if (!m_valid || rdy) begin m_data = nb; m_valid = 1; end
                    else m_ovr = 1;
                end else if (m_valid && rdy) begin
                    m_valid = 0;
                end
            end
            #1;
            check("valid_o", valid_o, m_valid);
            check("data_o", data_o, m_data);
            check("frame_err_o", frame_err_o, m_ferr);
            check("overrun_o", overrun_o, m_ovr);
            if (valid_o && (!prev_v || rdy)) begin
                ld_edge.push_back(edge_n);
                ld_data.push_back(data_o);
            end
            prev_v = valid_o;
            dut_ferr_cnt += int'(frame_err_o);
            dut_ovr_cnt  += int'(overrun_o);
        end
    end

    initial begin
        int s, s2, n0, f0, o0, extra;
        logic [7:0] b;
        logic st;
        n_checks = 0; n_errors = 0; edge_n = 0;
        dut_ferr_cnt = 0; dut_ovr_cnt = 0;
        rand_ready = 0;
        arstn_i = 0; rx_i = 1; ready_i = 1;
        repeat (3) tick();
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        arstn_i = 1;
        repeat (5) tick();

        // Single byte: latency and value
        n0 = ld_data.size(); f0 = dut_ferr_cnt; o0 = dut_ovr_cnt;
        send_frame(8'hA5, 1'b1, s);
        repeat (5) tick();
        check("t1_count", ld_data.size() - n0, 1);
        if (ld_data.size() > n0) begin
            check("t1_latency", ld_edge[n0] - s + 1, 50);
            check("t1_data", ld_data[n0], 8'hA5);
        end
        check("t1_errs", (dut_ferr_cnt - f0) + (dut_ovr_cnt - o0), 0);

        // Back-to-back frames
        n0 = ld_data.size();
        send_frame(8'h3C, 1'b1, s);
        send_frame(8'hC3, 1'b1, s2);
        repeat (5) tick();
        check("t2_count", ld_data.size() - n0, 2);
        if (ld_data.size() > n0 + 1) begin
            check("t2_data0", ld_data[n0], 8'h3C);
            check("t2_data1", ld_data[n0+1], 8'hC3);
            check("t2_spacing", ld_edge[n0+1] - ld_edge[n0], 50);
        end

        // Overrun with ready low
        n0 = ld_data.size(); o0 = dut_ovr_cnt;
        ready_i = 0;
        send_frame(8'h11, 1'b1, s);
        send_frame(8'h22, 1'b1, s2);
        repeat (3) tick();
        check("t3_ovr", dut_ovr_cnt - o0, 1);
        check("t3_count", ld_data.size() - n0, 1);
        check("t3_held_valid", valid_o, 1);
        check("t3_held_data", data_o, 8'h11);
        ready_i = 1;
        repeat (2) tick();
        check("t3_consumed", valid_o, 0);
        check("t3_data_kept", data_o, 8'h11);

        // Framing error then recovery
        n0 = ld_data.size(); f0 = dut_ferr_cnt; o0 = dut_ovr_cnt;
        send_frame(8'h55, 1'b0, s);
        repeat (40) tick();
        rx_i = 1;
        repeat (5) tick();
        check("t4_ferr", dut_ferr_cnt - f0, 1);
        check("t4_no_byte", ld_data.size() - n0, 0);
        send_frame(8'h0F, 1'b1, s);
        repeat (5) tick();
        check("t4_count", ld_data.size() - n0, 1);
        if (ld_data.size() > n0) check("t4_data", ld_data[n0], 8'h0F);
        check("t4_ovr", dut_ovr_cnt - o0, 0);

        // One-cycle glitch
        n0 = ld_data.size(); f0 = dut_ferr_cnt;
        rx_i = 0;
        tick();
        rx_i = 1;
        repeat (20) tick();
        check("t5_no_byte", ld_data.size() - n0, 0);
        check("t5_no_ferr", dut_ferr_cnt - f0, 0);

        // Reset in the middle of data bit 4
        n0 = ld_data.size(); f0 = dut_ferr_cnt;
        rx_i = 0;
        repeat (CPB) tick();
        rx_i = 1;
        repeat (4 * CPB + 2) tick();
        arstn_i = 0;
        repeat (3) tick();
        arstn_i = 1;
        repeat (5) tick();
        send_frame(8'h81, 1'b1, s);
        repeat (5) tick();
        check("t6_count", ld_data.size() - n0, 1);
        if (ld_data.size() > n0) check("t6_data", ld_data[n0], 8'h81);
        check("t6_no_ferr", dut_ferr_cnt - f0, 0);

        // Random frames, stop bits, glitches and consumer stalls
        rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            send_frame(b, st, s);
            if (!st) begin
                extra = $urandom_range(0, 10);
                repeat (extra) tick();
                rx_i = 1;
                repeat ($urandom_range(2, 6)) tick();
            end else begin
                repeat ($urandom_range(0, 4)) tick();
            end
            if ($urandom_range(0, 7) == 0) begin
                rx_i = 0;
                tick();
                rx_i = 1;
                repeat (4) tick();
            end
        end
        rand_ready = 0;
        ready_i = 1;
        repeat (60) tick();
        check("events_drained", evq.size(), 0);
        check("final_valid", valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
